// File: rtl/sequenciador_movimentos_pkg.sv
// Shared types for the move sequencer: move-code width and FSM state codes
// (the state codes are also exported on db_estado).
package sequenciador_movimentos_pkg;

  localparam int MOVE_W = 3;

  typedef logic [MOVE_W-1:0] move_t;

  typedef enum logic [3:0] {
    OCIOSO  = 4'd0,
    EMITE   = 4'd1,
    AGUARDA = 4'd2,
    PROXIMO = 4'd3,
    FIM     = 4'd4,
    ERRO    = 4'd5
  } estado_e;

  function automatic logic em_execucao(estado_e s);
    return (s == EMITE) || (s == AGUARDA) || (s == PROXIMO);
  endfunction

endpackage

// File: rtl/sequenciador_movimentos_if.sv
// Move handshake between the sequencer (master) and the servo manager (slave).
interface sequenciador_movimentos_if;
  import sequenciador_movimentos_pkg::*;

  logic  inicia_servos;
  move_t move_servos;
  logic  pronto_servos;

  modport master (output inicia_servos, output move_servos, input pronto_servos);
  modport slave  (input inicia_servos, input move_servos, output pronto_servos);
endinterface

// File: rtl/sequenciador_movimentos_buffer.sv
// Move buffer: PROFUNDIDADE x MOVE_W register file with synchronous append,
// combinational read at rd_ptr, and the write pointer / fill count.
module buffer_movimentos
  import sequenciador_movimentos_pkg::*;
#(
  parameter  int PROFUNDIDADE = 32,
  localparam int AW           = $clog2(PROFUNDIDADE)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          escreve,
  input  logic          limpa,
  input  move_t         move_in,
  input  logic [AW-1:0] rd_ptr,
  output move_t         move_out,
  output logic          cheio,
  output logic [AW:0]   num_movimentos
);

  move_t         mem_q [PROFUNDIDADE];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          grava;

  assign cheio          = (count_q == (AW+1)'(PROFUNDIDADE));
  assign num_movimentos = count_q;
  assign move_out       = mem_q[rd_ptr];

  // NOTE: every signal gets a default before the branches so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    grava    = 1'b0;
    if (limpa) begin
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (escreve && !cheio) begin
      grava    = 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
      count_d  = count_q + 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignments so all of them update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; entries at or beyond count are never read.
  always_ff @(posedge clock) begin
    if (grava) mem_q[wr_ptr_q] <= move_in;
  end

endmodule

// File: rtl/sequenciador_movimentos.sv
// Move sequencer: replays the buffered moves to the servo manager one at a
// time, waiting for each completion, with a per-move completion timeout.
module sequenciador_movimentos
  import sequenciador_movimentos_pkg::*;
#(
  parameter  int PROFUNDIDADE   = 32,
  parameter  int TIMEOUT_CICLOS = 150_000_000,
  localparam int AW             = $clog2(PROFUNDIDADE),
  localparam int TW             = $clog2(TIMEOUT_CICLOS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      escreve,
  input  move_t                     move_in,
  input  logic                      limpa,
  input  logic                      executa,
  sequenciador_movimentos_if.master servo_if,
  output logic                      ocupado,
  output logic                      pronto,
  output logic                      erro,
  output logic                      cheio,
  output logic [AW:0]               num_movimentos,
  output logic [AW:0]               movimento_atual,
  output logic [3:0]                db_estado
);

  estado_e       estado_q, estado_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   atual_q, atual_d;
  logic [TW-1:0] timer_q, timer_d;
  move_t         move_q, move_d;
  move_t         buf_move;
  logic          buf_escreve, buf_limpa;

  buffer_movimentos #(.PROFUNDIDADE(PROFUNDIDADE)) u_buffer (
    .clock          (clock),
    .reset          (reset),
    .escreve        (buf_escreve),
    .limpa          (buf_limpa),
    .move_in        (move_in),
    .rd_ptr         (rd_ptr_q),
    .move_out       (buf_move),
    .cheio          (cheio),
    .num_movimentos (num_movimentos)
  );

  always_comb begin
    estado_d    = estado_q;
    rd_ptr_d    = rd_ptr_q;
    atual_d     = atual_q;
    timer_d     = timer_q;
    move_d      = move_q;
    buf_escreve = 1'b0;
    buf_limpa   = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (limpa) begin
          buf_limpa = 1'b1;
        end else if (executa) begin
          if (num_movimentos == '0) begin
            estado_d = FIM;
          end else begin
            rd_ptr_d = '0;
            atual_d  = '0;
            estado_d = EMITE;
          end
        end else if (escreve) begin
          buf_escreve = 1'b1;
        end
      end
      EMITE: begin
        move_d   = buf_move;
        timer_d  = '0;
        estado_d = AGUARDA;
      end
      AGUARDA: begin
        // Completion is checked first so it wins over a simultaneous timeout.
        if (servo_if.pronto_servos)                     estado_d = PROXIMO;
        else if (timer_q == TW'(TIMEOUT_CICLOS - 1))    estado_d = ERRO;
        else                                            timer_d  = timer_q + 1'b1;
      end
      PROXIMO: begin
        atual_d  = atual_q + 1'b1;
        rd_ptr_d = rd_ptr_q + 1'b1;
        estado_d = (atual_q + 1'b1 == num_movimentos) ? FIM : EMITE;
      end
      FIM: begin
        buf_limpa = 1'b1;
        move_d    = '0;
        estado_d  = OCIOSO;
      end
      ERRO: begin
        if (limpa) begin
          buf_limpa = 1'b1;
          estado_d  = OCIOSO;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= OCIOSO;
      rd_ptr_q <= '0;
      atual_q  <= '0;
      timer_q  <= '0;
      move_q   <= '0;
    end else begin
      estado_q <= estado_d;
      rd_ptr_q <= rd_ptr_d;
      atual_q  <= atual_d;
      timer_q  <= timer_d;
      move_q   <= move_d;
    end
  end

  // The move is presented straight from the buffer in EMITE so it is valid with the strobe.
  assign servo_if.inicia_servos = (estado_q == EMITE);
  assign servo_if.move_servos   = (estado_q == EMITE) ? buf_move : move_q;
  assign ocupado                = em_execucao(estado_q);
  assign pronto                 = (estado_q == FIM);
  assign erro                   = (estado_q == ERRO);
  assign movimento_atual        = atual_q;
  assign db_estado              = estado_q;

endmodule

// File: tb/tb_sequenciador_movimentos.sv
// Self-checking bench for sequenciador_movimentos: a queue model of the buffer
// predicts the issued moves; a responder plays the servo manager.
module tb_sequenciador_movimentos;
  import sequenciador_movimentos_pkg::*;

  localparam int PROF = 4;
  localparam int TMO  = 100;
  localparam int AW   = $clog2(PROF);

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        escreve = 1'b0, limpa = 1'b0, executa = 1'b0;
  move_t       move_in = '0;
  logic        ocupado, pronto, erro, cheio;
  logic [AW:0] num_movimentos, movimento_atual;
  logic [3:0]  db_estado;

  sequenciador_movimentos_if sif ();

  sequenciador_movimentos #(.PROFUNDIDADE(PROF), .TIMEOUT_CICLOS(TMO)) dut (
    .clock           (clock),
    .reset           (reset),
    .escreve         (escreve),
    .move_in         (move_in),
    .limpa           (limpa),
    .executa         (executa),
    .servo_if        (sif),
    .ocupado         (ocupado),
    .pronto          (pronto),
    .erro            (erro),
    .cheio           (cheio),
    .num_movimentos  (num_movimentos),
    .movimento_atual (movimento_atual),
    .db_estado       (db_estado)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clock) cyc++;

  // Monitor + servo-manager responder, evaluated on the falling edge.
  move_t issued_q[$];
  int    gap_q[$];
  int    inicia_cnt = 0, pronto_cnt = 0;
  int    resp_delay = 10, resp_hold = 1;
  bit    resp_en = 1'b1;
  int    cd = -1, hd = 0, last_resp_cyc = -1;

  initial sif.pronto_servos = 1'b0;

  always @(negedge clock) begin
    if (sif.inicia_servos) begin
      inicia_cnt++;
      issued_q.push_back(sif.move_servos);
      if (last_resp_cyc >= 0) gap_q.push_back(cyc - last_resp_cyc);
      last_resp_cyc = -1;
      if (resp_en) cd = resp_delay;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        hd = resp_hold;
        cd = -1;
      end
    end
    if (pronto) begin
      pronto_cnt++;
      if (last_resp_cyc >= 0) gap_q.push_back(cyc - last_resp_cyc);
      last_resp_cyc = -1;
    end
    if (hd > 0) begin
      if (!sif.pronto_servos && ocupado) last_resp_cyc = cyc;
      sif.pronto_servos = 1'b1;
      hd--;
    end else begin
      sif.pronto_servos = 1'b0;
    end
  end

  // Reference model: the buffer is just a bounded queue of moves.
  move_t model_q[$];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic write_move(move_t m);
    escreve = 1'b1;
    move_in = m;
    tick();
    escreve = 1'b0;
    if (model_q.size() < PROF) model_q.push_back(m);
  endtask

  task automatic check_idle(string tag);
    check({tag, "_inicia"}, sif.inicia_servos, 0);
    check({tag, "_move"}, sif.move_servos, 0);
    check({tag, "_ocupado"}, ocupado, 0);
    check({tag, "_pronto"}, pronto, 0);
    check({tag, "_erro"}, erro, 0);
    check({tag, "_cheio"}, cheio, 0);
    check({tag, "_num"}, num_movimentos, 0);
    check({tag, "_atual"}, movimento_atual, 0);
    check({tag, "_estado"}, db_estado, 0);
  endtask

  // Pulses executa (escreve may already be driven by the caller), waits for
  // pronto and compares the issued moves against the model.
  task automatic run_and_check(string tag);
    move_t exp_q[$];
    int    p0;
    exp_q = model_q;
    issued_q.delete();
    gap_q.delete();
    p0 = pronto_cnt;
    executa = 1'b1;
    tick();
    executa = 1'b0;
    escreve = 1'b0;
    check({tag, "_lat_inicia"}, sif.inicia_servos, 1);
    for (int i = 0; i < 3000 && pronto_cnt == p0; i++) tick();
    check({tag, "_done"}, pronto_cnt - p0, 1);
    tick();
    check({tag, "_pronto_pulse"}, pronto, 0);
    check({tag, "_n_issued"}, issued_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < issued_q.size()) check($sformatf("%s_move%0d", tag, i), issued_q[i], exp_q[i]);
    foreach (gap_q[i]) check($sformatf("%s_gap%0d", tag, i), gap_q[i], 2);
    check({tag, "_num_after"}, num_movimentos, 0);
    model_q.delete();
  endtask

  initial begin
    int base;

    // Reset state.
    repeat (3) tick();
    check_idle("reset");
    reset = 1'b0;
    tick();

    // Directed sequence 5,2,7 with a 10-cycle responder.
    write_move(3'd5);
    write_move(3'd2);
    write_move(3'd7);
    check("load3_num", num_movimentos, 3);
    run_and_check("seq527");

    // Fill past capacity: the fifth write is dropped.
    for (int i = 0; i < 5; i++) begin
      write_move(move_t'($urandom_range(0, 7)));
      check($sformatf("fill%0d_cheio", i), cheio, model_q.size() == PROF);
      check($sformatf("fill%0d_num", i), num_movimentos, model_q.size());
    end
    run_and_check("full");

    // Responder never answers: timeout after TMO cycles in AGUARDA.
    resp_en = 1'b0;
    write_move(move_t'($urandom_range(0, 7)));
    write_move(move_t'($urandom_range(0, 7)));
    base = inicia_cnt;
    executa = 1'b1;
    tick();
    executa = 1'b0;
    check("tmo_inicia", sif.inicia_servos, 1);
    repeat (TMO) tick();
    check("tmo_erro_early", erro, 0);
    tick();
    check("tmo_erro", erro, 1);
    check("tmo_estado", db_estado, 5);
    repeat (20) tick();
    check("tmo_no_more_inicia", inicia_cnt - base, 1);
    check("tmo_erro_held", erro, 1);
    check("tmo_ocupado", ocupado, 0);
    limpa = 1'b1;
    tick();
    limpa = 1'b0;
    check("limpa_estado", db_estado, 0);
    check("limpa_erro", erro, 0);
    check("limpa_num", num_movimentos, 0);
    model_q.delete();
    resp_en = 1'b1;

    // Executa with an empty buffer: immediate pronto, no inicia.
    base = inicia_cnt;
    executa = 1'b1;
    tick();
    executa = 1'b0;
    check("empty_pronto", pronto, 1);
    check("empty_estado", db_estado, 4);
    tick();
    check("empty_pronto_off", pronto, 0);
    check("empty_no_inicia", inicia_cnt - base, 0);

    // escreve+executa together: the write is dropped; long pronto_servos.
    resp_hold = 5;
    write_move(move_t'($urandom_range(0, 7)));
    escreve = 1'b1;
    move_in = move_t'($urandom_range(0, 7));
    run_and_check("wr_exec");
    base = inicia_cnt;
    repeat (8) tick();
    check("hold_no_double", inicia_cnt - base, 0);
    check("hold_ocupado", ocupado, 0);
    resp_hold = 1;

    // Reset while waiting on move 2 of 3.
    resp_delay = 10;
    for (int i = 0; i < 3; i++) write_move(move_t'($urandom_range(0, 7)));
    base = inicia_cnt;
    executa = 1'b1;
    tick();
    executa = 1'b0;
    for (int i = 0; i < 200 && inicia_cnt - base < 2; i++) tick();
    check("rst_second_inicia", inicia_cnt - base, 2);
    repeat (3) tick();
    check("rst_in_aguarda", db_estado, 2);
    reset = 1'b1;
    tick();
    check_idle("midrun_reset");
    reset = 1'b0;
    repeat (20) tick();
    check("rst_no_more_inicia", inicia_cnt - base, 2);
    check("rst_estado", db_estado, 0);
    check("rst_ocupado", ocupado, 0);
    model_q.delete();

    // Randomized runs.
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, PROF);
      resp_delay = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) write_move(move_t'($urandom_range(0, 7)));
      run_and_check($sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
